// File: rtl/hub_pkg.sv
// hub_pkg: shared constants for the peripheral hub and its interrupt controller.
package hub_pkg;
    localparam int unsigned CTRL_PENDING = 0;
    localparam int unsigned CTRL_MASK    = 1;
    localparam int unsigned CTRL_EDGE    = 2;
    localparam int unsigned CTRL_RAW     = 3;
    localparam int unsigned NCH_MAX      = 8;
    localparam int unsigned HWINT_W      = 6;
endpackage

// File: rtl/irq_ctrl.sv
// irq_ctrl: per-channel PENDING/MASK/EDGE/RAW registers, edge detect and folding onto the 6-bit HWInt vector.
module irq_ctrl import hub_pkg::*; #(
    parameter int          NCH      = 6,
    parameter logic [7:0]  MASK_RST = 8'hFF
) (
    input  logic               clk,
    input  logic               sys_rstn,
    input  logic               wr,
    input  logic [31:0]        off,
    input  logic [NCH-1:0]     wd,
    input  logic [NCH-1:0]     dev_irq,
    output logic [31:0]        rd_data,
    output logic [HWINT_W-1:0] hw_int
);
    logic [NCH-1:0]     pending, mask, edge_en, irq_prev, clr, pend_nxt;
    logic [NCH_MAX-1:0] act_p, rd_p;
    logic [HWINT_W-1:0] hw_nxt;

    always_comb begin
        clr = (wr && off == CTRL_PENDING) ? wd : '0;
        // edge channels latch rises until cleared; a rise beats a same-cycle clear
        pend_nxt = (edge_en & ((pending & ~clr) | (dev_irq & ~irq_prev))) | (~edge_en & dev_irq);
        act_p = '0;
        act_p[NCH-1:0] = pending & mask;
        hw_nxt = {|act_p[NCH_MAX-1:5], act_p[4:0]};
        rd_p = '0;
        rd_p[NCH-1:0] = off == CTRL_PENDING ? pending :
                        off == CTRL_MASK    ? mask    :
                        off == CTRL_EDGE    ? edge_en :
                        off == CTRL_RAW     ? irq_prev : '0;
        rd_data = {{(32-NCH_MAX){1'b0}}, rd_p};
    end

    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            pending  <= '0;
            mask     <= MASK_RST[NCH-1:0];
            edge_en  <= '0;
            irq_prev <= '0;
            hw_int   <= '0;
        end else begin
            irq_prev <= dev_irq;
            pending  <= pend_nxt;
            hw_int   <= hw_nxt;
            if (wr && off == CTRL_MASK) mask <= wd;
            if (wr && off == CTRL_EDGE) edge_en <= wd;
        end
    end
endmodule

// File: rtl/periph_hub.sv
// periph_hub: address-window bridge from the CPU Pr* bus to NCH devices plus a control window
// for the interrupt controller; writes fan out combinationally, reads return one cycle later.
module periph_hub import hub_pkg::*; #(
    parameter int          NCH      = 6,
    parameter int          WIN_BITS = 2,
    parameter logic [31:0] BASE     = 32'h0000_7F00,
    parameter logic [7:0]  MASK_RST = 8'hFF
) (
    input  logic                clk,
    input  logic                sys_rstn,
    input  logic [29:0]         pr_addr,
    input  logic [31:0]         pr_wd,
    input  logic [3:0]          pr_be,
    input  logic                pr_we,
    input  logic                pr_re,
    output logic [31:0]         pr_rd,
    output logic                rd_valid,
    output logic                bus_err,
    output logic [WIN_BITS-1:0] dev_addr,
    output logic [31:0]         dev_wd,
    output logic [3:0]          dev_be,
    output logic [NCH-1:0]      dev_we,
    input  logic [32*NCH-1:0]   dev_rd,
    input  logic [NCH-1:0]      dev_irq,
    output logic [HWINT_W-1:0]  hw_int
);
    logic [31:0] a, diff, ch, off, ctrl_rd, rd_mux;
    logic        mapped, ctrl_hit;

    // addresses below BASE wrap to a huge channel index and fall out as unmapped
    assign a        = {pr_addr, 2'b00};
    assign diff     = a - BASE;
    assign ch       = diff >> (WIN_BITS + 2);
    assign off      = (diff >> 2) & ((32'd1 << WIN_BITS) - 32'd1);
    assign mapped   = ch <= 32'(NCH);
    assign ctrl_hit = ch == 32'(NCH);
    assign dev_addr = a[WIN_BITS+1:2];
    assign dev_wd   = pr_wd;
    assign dev_be   = pr_be;

    always_comb begin
        dev_we = '0;
        rd_mux = ctrl_hit ? ctrl_rd : '0;
        for (int k = 0; k < NCH; k++) begin
            dev_we[k] = pr_we && ch == 32'(k);
            if (ch == 32'(k)) rd_mux = dev_rd[k*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            pr_rd    <= '0;
            rd_valid <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            rd_valid <= pr_re;
            bus_err  <= (pr_we || pr_re) && !mapped;
            if (pr_re) pr_rd <= rd_mux;
        end
    end

    irq_ctrl #(.NCH(NCH), .MASK_RST(MASK_RST)) u_irq (
        .clk     (clk),
        .sys_rstn(sys_rstn),
        .wr      (pr_we && ctrl_hit && pr_be[0]),
        .off     (off),
        .wd      (pr_wd[NCH-1:0]),
        .dev_irq (dev_irq),
        .rd_data (ctrl_rd),
        .hw_int  (hw_int)
    );
endmodule
